qic117_status_decoder: RTL and testbench
========================================

QIC117_STATUS_DECODER -- requirements
Module: qic117_status_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 200_000_000, meaning the system clock frequency in Hz; it must be an integer multiple of 1_000_000.
REQ-002 SHALL have parameter MIN_LOW_US, default 250, meaning low pulses shorter than this are glitches.
REQ-003 SHALL have parameter BIT_THRESH_US, default 1000, meaning a low width >= this decodes as 1, otherwise 0.
REQ-004 SHALL have parameter MAX_LOW_US, default 2500, meaning a low width above this is an error.
REQ-005 SHALL have parameter GAP_TIMEOUT_US, default 3000, meaning the longest high time allowed between bits of one word.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port enable, input, 1 bit: decoder active (tape mode).
REQ-009 SHALL have port trk0_in, input, 1 bit: raw TRK0 line, asynchronous to clk, idle high.
REQ-010 SHALL have port status_word, output, 8 bits: last complete word, MSB received first.
REQ-011 SHALL have port status_valid, output, 1 bit: one-cycle pulse when status_word updates.
REQ-012 SHALL have port rx_error, output, 1 bit: one-cycle pulse on a decode error.
REQ-013 SHALL have port err_code, output, 2 bits: 01 = low too long, 10 = gap timeout; holds until the next error.
REQ-014 SHALL have port busy, output, 1 bit: word reception in progress.
REQ-015 SHALL have port bit_count, output, 4 bits: bits received in the current word (0-7).

Function
REQ-016 SHALL pass trk0_in through a 2-flop synchronizer; edge detection operates on the synchronized value and its one-cycle-delayed copy.
REQ-017 SHALL generate a 1 µs tick from a prescaler counting 0..CLK_FREQ_HZ/1e6-1; the prescaler restarts at 0 on every detected edge.
REQ-018 SHALL measure low and gap durations in a 12-bit µs counter that saturates at 4095 and clears on entry to LOW or GAP.
REQ-019 SHALL implement states IDLE, LOW, GAP and WAIT_HIGH.
REQ-020 IDLE: busy=0, bit_count=0; a synchronized falling edge -> LOW.
REQ-021 LOW: busy=1; when the counter exceeds MAX_LOW_US -> rx_error pulse, err_code=01, bit_count=0, go to WAIT_HIGH.
REQ-022 LOW, rising edge with width < MIN_LOW_US: glitch, nothing shifted, no error; return to IDLE if bit_count=0, else to GAP with the gap counter cleared.
REQ-023 LOW, rising edge with valid width: shift bit (width >= BIT_THRESH_US) into the shift register LSB; the shift register shifts left.
- Below 8 bits: bit_count increments, go to GAP.
- On the 8th bit: in the cycle after the rising edge is detected, status_word=shifted value, status_valid=1 for one cycle, bit_count=0, go to IDLE.
REQ-024 GAP: busy=1; a falling edge -> LOW; when the counter exceeds GAP_TIMEOUT_US -> rx_error pulse, err_code=10, bit_count=0, go to IDLE (the partial word is discarded).
REQ-025 GAP: if a falling edge and the timeout condition occur in the same cycle, the edge wins (no error).
REQ-026 WAIT_HIGH: busy=1; stay until the synchronized line is high, then go to IDLE; no bits are decoded in this state.
REQ-027 SHALL, while enable=0, synchronously force IDLE, bit_count=0, busy=0 and suppress the pulses; status_word and err_code are retained.
REQ-028 If enable rises while the line is low, SHALL not decode that pulse (a falling edge is required).
REQ-029 Widths exactly equal to a threshold: width = MIN_LOW_US is valid, width = BIT_THRESH_US decodes as 1, width = MAX_LOW_US is valid, gap = GAP_TIMEOUT_US is not a timeout.

Reset
REQ-030 SHALL, on reset_n low, asynchronously set:
- state=IDLE, status_word=8'h00, status_valid=0, rx_error=0, err_code=00, busy=0, bit_count=0;
- synchronizer flops=1, prescaler=0, counter=0, shift register=0.
REQ-031 Reset asserted mid-word SHALL discard all partial data; the first falling edge after release starts a new word.

Verification
REQ-032 Bench SHALL drive 8 pulses for 0xA4 (1500/500 µs lows, 1000 µs gaps) -> status_valid once, status_word=8'hA4, rx_error never asserted.
REQ-033 Bench SHALL drive an encoder-style word 0xE4 with a 100 µs glitch low inserted in the 3rd gap -> status_word=8'hE4, no error, bit_count never exceeds 7.
REQ-034 Bench SHALL drive a 2600 µs low as the 2nd bit -> rx_error pulse, err_code=01, busy held until the line rises, then IDLE with bit_count=0.
REQ-035 Bench SHALL send 3 bits, then hold high 3100 µs -> rx_error pulse, err_code=10, status_word unchanged from its prior value.
REQ-036 Bench SHALL deassert enable after 4 bits, re-enable, then send 0x81 -> status_word=8'h81.
REQ-037 Bench SHALL assert reset_n low mid-word -> all outputs return to reset values immediately, without waiting for a clock edge.
REQ-038 Bench SHALL drive lows of exactly 250, 1000 and 2500 µs -> all three accepted, decoded as 0, 1 and 1 respectively.

Source files
------------

// File: rtl/qic117_status_decoder.sv
// QIC-117 TRK0 status-word decoder: measures low-pulse widths on the TRK0 line
// and assembles 8-bit status words, MSB first, with glitch, length and gap checks.
module qic117_status_decoder #(
  parameter int CLK_FREQ_HZ    = 200_000_000,
  parameter int MIN_LOW_US     = 250,
  parameter int BIT_THRESH_US  = 1000,
  parameter int MAX_LOW_US     = 2500,
  parameter int GAP_TIMEOUT_US = 3000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       trk0_in,
  output logic [7:0] status_word,
  output logic       status_valid,
  output logic       rx_error,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [3:0] bit_count
);

  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [11:0] MIN_W    = 12'(MIN_LOW_US);
  localparam logic [11:0] THRESH_W = 12'(BIT_THRESH_US);
  localparam logic [11:0] MAX_W    = 12'(MAX_LOW_US);
  localparam logic [11:0] GAP_W    = 12'(GAP_TIMEOUT_US);

  typedef enum logic [1:0] {IDLE, LOW, GAP, WAIT_HIGH} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, dly_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [11:0]   cnt_q, cnt_d, cnt_now;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    status_word_q, status_word_d;
  logic          status_valid_q, status_valid_d;
  logic          rx_error_q, rx_error_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          busy_q, busy_d;
  logic [3:0]    bit_count_q, bit_count_d;
  logic          fall, rise, tick, clear_cnt, bit_val;

  assign fall = dly_q & ~sync2_q;
  assign rise = ~dly_q & sync2_q;
  assign tick = (presc_q == PRESC_MAX);

  // cnt_now includes the tick of the current cycle, so it equals the whole
  // microseconds elapsed since the state was entered.
  assign cnt_now = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + {11'd0, tick};
  assign bit_val = (cnt_now >= THRESH_W);

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    status_word_d  = status_word_q;
    status_valid_d = 1'b0;
    rx_error_d     = 1'b0;
    err_code_d     = err_code_q;
    bit_count_d    = bit_count_q;
    clear_cnt      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = LOW;
          clear_cnt = 1'b1;
        end
      end
      LOW: begin
        if (cnt_now > MAX_W) begin
          rx_error_d  = 1'b1;
          err_code_d  = 2'b01;
          bit_count_d = 4'd0;
          state_d     = WAIT_HIGH;
        end else if (rise) begin
          if (cnt_now < MIN_W) begin
            if (bit_count_q == 4'd0) begin
              state_d = IDLE;
            end else begin
              state_d   = GAP;
              clear_cnt = 1'b1;
            end
          end else begin
            shift_d = {shift_q[6:0], bit_val};
            if (bit_count_q == 4'd7) begin
              status_word_d  = {shift_q[6:0], bit_val};
              status_valid_d = 1'b1;
              bit_count_d    = 4'd0;
              state_d        = IDLE;
            end else begin
              bit_count_d = bit_count_q + 4'd1;
              state_d     = GAP;
              clear_cnt   = 1'b1;
            end
          end
        end
      end
      GAP: begin
        // A falling edge beats a simultaneous timeout.
        if (fall) begin
          state_d   = LOW;
          clear_cnt = 1'b1;
        end else if (cnt_now > GAP_W) begin
          rx_error_d  = 1'b1;
          err_code_d  = 2'b10;
          bit_count_d = 4'd0;
          state_d     = IDLE;
        end
      end
      WAIT_HIGH: begin
        if (sync2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d        = IDLE;
      shift_d        = shift_q;
      status_word_d  = status_word_q;
      status_valid_d = 1'b0;
      rx_error_d     = 1'b0;
      err_code_d     = err_code_q;
      bit_count_d    = 4'd0;
      clear_cnt      = 1'b0;
    end

    busy_d  = (state_d != IDLE);
    cnt_d   = clear_cnt ? 12'd0 : cnt_now;
    presc_d = (fall | rise | tick) ? '0 : presc_q + PRESC_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      dly_q          <= 1'b1;
      presc_q        <= '0;
      cnt_q          <= 12'd0;
      shift_q        <= 8'h00;
      status_word_q  <= 8'h00;
      status_valid_q <= 1'b0;
      rx_error_q     <= 1'b0;
      err_code_q     <= 2'b00;
      busy_q         <= 1'b0;
      bit_count_q    <= 4'd0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= trk0_in;
      sync2_q        <= sync1_q;
      dly_q          <= sync2_q;
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      status_word_q  <= status_word_d;
      status_valid_q <= status_valid_d;
      rx_error_q     <= rx_error_d;
      err_code_q     <= err_code_d;
      busy_q         <= busy_d;
      bit_count_q    <= bit_count_d;
    end
  end

  assign status_word  = status_word_q;
  assign status_valid = status_valid_q;
  assign rx_error     = rx_error_q;
  assign err_code     = err_code_q;
  assign busy         = busy_q;
  assign bit_count    = bit_count_q;

endmodule

// File: tb/tb_qic117_status_decoder.sv
// Directed bench for qic117_status_decoder; runs at 1 MHz so one clock is one microsecond.
module tb_qic117_status_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       trk0_in;
  logic [7:0] status_word;
  logic       status_valid;
  logic       rx_error;
  logic [1:0] err_code;
  logic       busy;
  logic [3:0] bit_count;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int max_bc = 0;

  qic117_status_decoder #(
    .CLK_FREQ_HZ   (1_000_000),
    .MIN_LOW_US    (250),
    .BIT_THRESH_US (1000),
    .MAX_LOW_US    (2500),
    .GAP_TIMEOUT_US(3000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .trk0_in     (trk0_in),
    .status_word (status_word),
    .status_valid(status_valid),
    .rx_error    (rx_error),
    .err_code    (err_code),
    .busy        (busy),
    .bit_count   (bit_count)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, cleared by the stimulus between scenarios.
  always @(negedge clk) begin
    if (status_valid === 1'b1) valid_cnt++;
    if (rx_error === 1'b1) err_cnt++;
    if (int'(bit_count) > max_bc) max_bc = int'(bit_count);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_us(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int low_us, input int gap_us);
    trk0_in = 1'b0;
    wait_us(low_us);
    trk0_in = 1'b1;
    wait_us(gap_us);
  endtask

  task automatic send_word(input logic [7:0] w, input int gap_us);
    for (int i = 7; i >= 0; i--) applyStimulus(w[i] ? 1500 : 500, gap_us);
  endtask

  task automatic clear_counts();
    valid_cnt = 0;
    err_cnt   = 0;
    max_bc    = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    trk0_in = 1'b1;
    wait_us(5);
    checkOutput("rst_word",  32'(status_word),  32'h00);
    checkOutput("rst_valid", 32'(status_valid), 32'h0);
    checkOutput("rst_err",   32'(rx_error),     32'h0);
    checkOutput("rst_code",  32'(err_code),     32'h0);
    checkOutput("rst_busy",  32'(busy),         32'h0);
    checkOutput("rst_bc",    32'(bit_count),    32'h0);
    reset_n = 1'b1;
    enable  = 1'b1;
    wait_us(5);

    $display("[TB] word 0xA4, 1000 us gaps");
    clear_counts();
    for (int i = 7; i >= 0; i--) begin
      applyStimulus((8'hA4 >> i) & 1 ? 1500 : 500, 1000);
      if (i == 5) begin
        checkOutput("a4_mid_bc",   32'(bit_count), 32'd3);
        checkOutput("a4_mid_busy", 32'(busy),      32'h1);
      end
    end
    checkOutput("a4_word",  32'(status_word), 32'hA4);
    checkOutput("a4_valid", 32'(valid_cnt),   32'd1);
    checkOutput("a4_err",   32'(err_cnt),     32'd0);
    checkOutput("a4_busy",  32'(busy),        32'h0);
    checkOutput("a4_bc",    32'(bit_count),   32'h0);

    $display("[TB] word 0xE4 with glitch in third gap");
    clear_counts();
    applyStimulus(1500, 300);
    applyStimulus(1500, 300);
    applyStimulus(1500, 300);
    applyStimulus(100, 300);
    checkOutput("e4_glitch_bc", 32'(bit_count), 32'd3);
    applyStimulus(500, 300);
    applyStimulus(500, 300);
    applyStimulus(1500, 300);
    applyStimulus(500, 300);
    applyStimulus(500, 300);
    checkOutput("e4_word",  32'(status_word), 32'hE4);
    checkOutput("e4_valid", 32'(valid_cnt),   32'd1);
    checkOutput("e4_err",   32'(err_cnt),     32'd0);
    checkOutput("e4_maxbc", 32'(max_bc),      32'd7);

    $display("[TB] 2600 us low as second bit");
    clear_counts();
    applyStimulus(1500, 300);
    trk0_in = 1'b0;
    wait_us(2550);
    checkOutput("long_err",  32'(err_cnt),   32'd1);
    checkOutput("long_code", 32'(err_code),  32'h1);
    checkOutput("long_busy", 32'(busy),      32'h1);
    checkOutput("long_bc",   32'(bit_count), 32'h0);
    wait_us(50);
    trk0_in = 1'b1;
    wait_us(10);
    checkOutput("long_idle_busy", 32'(busy),      32'h0);
    checkOutput("long_idle_bc",   32'(bit_count), 32'h0);
    checkOutput("long_valid",     32'(valid_cnt), 32'd0);
    checkOutput("long_err_once",  32'(err_cnt),   32'd1);

    $display("[TB] gap timeout after 3 bits");
    clear_counts();
    applyStimulus(500, 300);
    applyStimulus(1500, 300);
    applyStimulus(500, 3100);
    checkOutput("gap_err",   32'(err_cnt),     32'd1);
    checkOutput("gap_code",  32'(err_code),    32'h2);
    checkOutput("gap_word",  32'(status_word), 32'hE4);
    checkOutput("gap_busy",  32'(busy),        32'h0);
    checkOutput("gap_bc",    32'(bit_count),   32'h0);
    checkOutput("gap_valid", 32'(valid_cnt),   32'd0);

    $display("[TB] disable mid-word, then word 0x81");
    clear_counts();
    applyStimulus(1500, 300);
    applyStimulus(500, 300);
    applyStimulus(1500, 300);
    applyStimulus(500, 300);
    checkOutput("en_mid_bc", 32'(bit_count), 32'd4);
    enable = 1'b0;
    wait_us(3);
    checkOutput("en_off_busy", 32'(busy),        32'h0);
    checkOutput("en_off_bc",   32'(bit_count),   32'h0);
    checkOutput("en_off_word", 32'(status_word), 32'hE4);
    checkOutput("en_off_code", 32'(err_code),    32'h2);
    trk0_in = 1'b0;
    wait_us(20);
    enable = 1'b1;
    wait_us(500);
    trk0_in = 1'b1;
    wait_us(300);
    checkOutput("en_low_busy", 32'(busy),      32'h0);
    checkOutput("en_low_bc",   32'(bit_count), 32'h0);
    send_word(8'h81, 300);
    checkOutput("en_word",  32'(status_word), 32'h81);
    checkOutput("en_valid", 32'(valid_cnt),   32'd1);
    checkOutput("en_err",   32'(err_cnt),     32'd0);

    $display("[TB] exact thresholds 250/1000/2500 us, 3000 us gap");
    clear_counts();
    applyStimulus(250, 3000);
    checkOutput("thr_bc1", 32'(bit_count), 32'd1);
    applyStimulus(1000, 300);
    applyStimulus(2500, 300);
    checkOutput("thr_bc3", 32'(bit_count), 32'd3);
    applyStimulus(500, 300);
    applyStimulus(1500, 300);
    applyStimulus(500, 300);
    applyStimulus(1500, 300);
    applyStimulus(500, 300);
    checkOutput("thr_word",  32'(status_word), 32'h6A);
    checkOutput("thr_valid", 32'(valid_cnt),   32'd1);
    checkOutput("thr_err",   32'(err_cnt),     32'd0);

    $display("[TB] asynchronous reset mid-word");
    clear_counts();
    applyStimulus(1500, 300);
    applyStimulus(1500, 300);
    trk0_in = 1'b0;
    wait_us(100);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_busy",  32'(busy),         32'h0);
    checkOutput("arst_bc",    32'(bit_count),    32'h0);
    checkOutput("arst_word",  32'(status_word),  32'h00);
    checkOutput("arst_code",  32'(err_code),     32'h0);
    checkOutput("arst_valid", 32'(status_valid), 32'h0);
    trk0_in = 1'b1;
    wait_us(5);
    reset_n = 1'b1;
    wait_us(5);
    send_word(8'h01, 300);
    checkOutput("arst_new_word",  32'(status_word), 32'h01);
    checkOutput("arst_new_valid", 32'(valid_cnt),   32'd1);
    checkOutput("arst_new_err",   32'(err_cnt),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
